// File: rtl/enigma_pkg.sv
// Shared types, wiring tables and mod-26 helpers for the Enigma rotor slice.
// Letters are 5-bit indices (0 = A) or 26-bit one-hot buses (bit 0 = A).
// Tables hold rotors I, II and III; the inverse tables serve the return path.
package enigma_pkg;

  localparam int unsigned LETTERS = 26;
  localparam int unsigned LW      = 5;

  typedef logic [LW-1:0]      letter_t;
  typedef logic [LETTERS-1:0] onehot_t;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_BWD = 1'b1
  } dir_e;

  localparam letter_t NOTCH_I   = 5'd16;  // Q
  localparam letter_t NOTCH_II  = 5'd4;   // E
  localparam letter_t NOTCH_III = 5'd21;  // V

  // EKMFLGDQVZNTOWYHXUSPAIBRCJ
  localparam letter_t WIRE_I_FWD [LETTERS] = '{
    5'd4,  5'd10, 5'd12, 5'd5,  5'd11, 5'd6,  5'd3,  5'd16, 5'd21, 5'd25,
    5'd13, 5'd19, 5'd14, 5'd22, 5'd24, 5'd7,  5'd23, 5'd20, 5'd18, 5'd15,
    5'd0,  5'd8,  5'd1,  5'd17, 5'd2,  5'd9};
  localparam letter_t WIRE_I_INV [LETTERS] = '{
    5'd20, 5'd22, 5'd24, 5'd6,  5'd0,  5'd3,  5'd5,  5'd15, 5'd21, 5'd25,
    5'd1,  5'd4,  5'd2,  5'd10, 5'd12, 5'd19, 5'd7,  5'd23, 5'd18, 5'd11,
    5'd17, 5'd8,  5'd13, 5'd16, 5'd14, 5'd9};

  // AJDKSIRUXBLHWTMCQGZNPYFVOE
  localparam letter_t WIRE_II_FWD [LETTERS] = '{
    5'd0,  5'd9,  5'd3,  5'd10, 5'd18, 5'd8,  5'd17, 5'd20, 5'd23, 5'd1,
    5'd11, 5'd7,  5'd22, 5'd19, 5'd12, 5'd2,  5'd16, 5'd6,  5'd25, 5'd13,
    5'd15, 5'd24, 5'd5,  5'd21, 5'd14, 5'd4};
  localparam letter_t WIRE_II_INV [LETTERS] = '{
    5'd0,  5'd9,  5'd15, 5'd2,  5'd25, 5'd22, 5'd17, 5'd11, 5'd5,  5'd1,
    5'd3,  5'd10, 5'd14, 5'd19, 5'd24, 5'd20, 5'd16, 5'd6,  5'd4,  5'd13,
    5'd7,  5'd23, 5'd12, 5'd8,  5'd21, 5'd18};

  // BDFHJLCPRTXVZNYEQGIKWUMOAS
  localparam letter_t WIRE_III_FWD [LETTERS] = '{
    5'd1,  5'd3,  5'd5,  5'd7,  5'd9,  5'd11, 5'd2,  5'd15, 5'd17, 5'd19,
    5'd23, 5'd21, 5'd25, 5'd13, 5'd24, 5'd4,  5'd16, 5'd6,  5'd8,  5'd10,
    5'd22, 5'd20, 5'd12, 5'd14, 5'd0,  5'd18};
  localparam letter_t WIRE_III_INV [LETTERS] = '{
    5'd24, 5'd0,  5'd6,  5'd1,  5'd15, 5'd2,  5'd17, 5'd3,  5'd18, 5'd4,
    5'd19, 5'd5,  5'd22, 5'd13, 5'd23, 5'd7,  5'd16, 5'd8,  5'd25, 5'd9,
    5'd21, 5'd11, 5'd20, 5'd10, 5'd14, 5'd12};

  function automatic letter_t notch_of(int unsigned id);
    case (id)
      2:       return NOTCH_II;
      3:       return NOTCH_III;
      default: return NOTCH_I;
    endcase
  endfunction

  // Wiring lookup; e must already be reduced to 0..25.
  function automatic letter_t wire_lookup(int unsigned id, dir_e dir, letter_t e);
    case (id)
      2:       return (dir == DIR_BWD) ? WIRE_II_INV[e]  : WIRE_II_FWD[e];
      3:       return (dir == DIR_BWD) ? WIRE_III_INV[e] : WIRE_III_FWD[e];
      default: return (dir == DIR_BWD) ? WIRE_I_INV[e]   : WIRE_I_FWD[e];
    endcase
  endfunction

  // Compare-and-correct modular add; both operands are 0..25.
  function automatic letter_t mod26_add(letter_t a, letter_t b);
    logic [LW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'(LETTERS)) s = s - 6'(LETTERS);
    return s[LW-1:0];
  endfunction

  // Compare-and-correct modular subtract; both operands are 0..25.
  function automatic letter_t mod26_sub(letter_t a, letter_t b);
    logic [LW:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (a < b) d = d + 6'(LETTERS);
    return d[LW-1:0];
  endfunction

endpackage

// File: rtl/rotor_map.sv
// Combinational rotor substitution for one direction.
// Ports: i_letter (one-hot in), i_pos (rotor position), i_dir (forward/inverse),
//        o_letter_c (one-hot out, 0 when input is not one-hot),
//        o_valid_onehot_c (input had exactly one bit set).
module rotor_map
  import enigma_pkg::*;
#(
  parameter int unsigned ROTOR_ID = 1
) (
  input  logic [25:0] i_letter,
  input  logic [4:0]  i_pos,
  input  logic        i_dir,
  output logic [25:0] o_letter_c,
  output logic        o_valid_onehot_c
);

  letter_t w_idx;
  letter_t w_entry;
  letter_t w_wired;
  letter_t w_result;
  logic    w_onehot;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  assign w_onehot = (i_letter != '0) && ((i_letter & (i_letter - 26'd1)) == '0);

  // Index of the set bit (only meaningful when w_onehot).
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < int'(LETTERS); i++) begin
      if (i_letter[i]) w_idx = letter_t'(i);
    end
  end

  // Rotor offset enters on the contact side and is removed on the exit side.
  assign w_entry  = mod26_add(w_idx, i_pos);
  assign w_wired  = wire_lookup(ROTOR_ID, dir_e'(i_dir), w_entry);
  assign w_result = mod26_sub(w_wired, i_pos);

  assign o_letter_c       = w_onehot ? (onehot_t'(26'd1) << w_result) : '0;
  assign o_valid_onehot_c = w_onehot;

endmodule

// File: rtl/rotor_stage.sv
// One Enigma rotor slice: stepping position counter plus registered forward
// (keyboard -> reflector) and backward (reflector -> lampboard) paths, latency 1.
// Ports: clk, reset (sync, active-high); load/init_pos set the position;
//        step_in/key step it; step_out carries to the next rotor; pos is the
//        position; fwd_*/bwd_* are the valid/one-hot letter paths; err is sticky.
// Optional macro ROTOR_DOUBLE_STEP_EN: also step when key=1 at the notch
// (middle-rotor double step); otherwise key is ignored.
module rotor_stage
  import enigma_pkg::*;
#(
  parameter int unsigned ROTOR_ID = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [4:0]  init_pos,
  input  logic        step_in,
  input  logic        key,
  output logic        step_out,
  output logic [4:0]  pos,
  input  logic        fwd_valid_in,
  input  logic [25:0] fwd_in,
  output logic        fwd_valid_out,
  output logic [25:0] fwd_out,
  input  logic        bwd_valid_in,
  input  logic [25:0] bwd_in,
  output logic        bwd_valid_out,
  output logic [25:0] bwd_out,
  output logic        err
);

  localparam letter_t NOTCH    = notch_of(ROTOR_ID);
  localparam letter_t LAST_POS = letter_t'(LETTERS - 1);

  letter_t     r_pos;
  logic        r_step_out;
  logic        r_fwd_valid;
  logic [25:0] r_fwd_out;
  logic        r_bwd_valid;
  logic [25:0] r_bwd_out;
  logic        r_err;

  logic        w_at_notch;
  logic        w_step;
  logic [25:0] w_fwd_map;
  logic        w_fwd_ok;
  logic [25:0] w_bwd_map;
  logic        w_bwd_ok;

  assign w_at_notch = (r_pos == NOTCH);

`ifdef ROTOR_DOUBLE_STEP_EN
  // Key at the notch steps this rotor as well; coinciding with step_in is one step.
  assign w_step = step_in | (key & w_at_notch);
`else
  // key has no effect in this build; the masked term keeps the port referenced.
  assign w_step = step_in | (key & 1'b0);
`endif

  rotor_map #(.ROTOR_ID(ROTOR_ID)) u_fwd_map (
    .i_letter         (fwd_in),
    .i_pos            (r_pos),
    .i_dir            (DIR_FWD),
    .o_letter_c       (w_fwd_map),
    .o_valid_onehot_c (w_fwd_ok)
  );

  rotor_map #(.ROTOR_ID(ROTOR_ID)) u_bwd_map (
    .i_letter         (bwd_in),
    .i_pos            (r_pos),
    .i_dir            (DIR_BWD),
    .o_letter_c       (w_bwd_map),
    .o_valid_onehot_c (w_bwd_ok)
  );

  // Position, carry, data paths and sticky error. Data uses the pre-edge position.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pos       <= '0;
      r_step_out  <= 1'b0;
      r_fwd_valid <= 1'b0;
      r_fwd_out   <= '0;
      r_bwd_valid <= 1'b0;
      r_bwd_out   <= '0;
      r_err       <= 1'b0;
    end else begin
      if (load) begin
        r_step_out <= 1'b0;
        if (init_pos <= LAST_POS) begin
          r_pos <= init_pos;
        end else begin
          r_pos <= '0;
          r_err <= 1'b1;
        end
      end else if (w_step) begin
        r_step_out <= w_at_notch;
        r_pos      <= (r_pos == LAST_POS) ? '0 : r_pos + 5'd1;
      end else begin
        r_step_out <= 1'b0;
      end

      r_fwd_valid <= fwd_valid_in;
      if (fwd_valid_in) begin
        r_fwd_out <= w_fwd_map;
        if (!w_fwd_ok) r_err <= 1'b1;
      end

      r_bwd_valid <= bwd_valid_in;
      if (bwd_valid_in) begin
        r_bwd_out <= w_bwd_map;
        if (!w_bwd_ok) r_err <= 1'b1;
      end
    end
  end

  assign pos           = r_pos;
  assign step_out      = r_step_out;
  assign fwd_valid_out = r_fwd_valid;
  assign fwd_out       = r_fwd_out;
  assign bwd_valid_out = r_bwd_valid;
  assign bwd_out       = r_bwd_out;
  assign err           = r_err;

endmodule

// File: tb/tb_rotor_stage.sv
// Self-checking bench for rotor_stage: directed steps followed by random
// traffic, all checked against a letter-level reference model built from the
// rotor's wiring string.
module tb_rotor_stage;

  localparam int unsigned ROTOR_ID = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [4:0]  init_pos;
  logic        step_in;
  logic        key;
  logic        step_out;
  logic [4:0]  pos;
  logic        fwd_valid_in;
  logic [25:0] fwd_in;
  logic        fwd_valid_out;
  logic [25:0] fwd_out;
  logic        bwd_valid_in;
  logic [25:0] bwd_in;
  logic        bwd_valid_out;
  logic [25:0] bwd_out;
  logic        err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  string       wiring;
  int          notch;
  int          m_pos;
  logic        m_so;
  logic        m_fv;
  logic [25:0] m_fo;
  logic        m_bv;
  logic [25:0] m_bo;
  logic        m_err;

  always #5 clk = ~clk;

  rotor_stage #(.ROTOR_ID(ROTOR_ID)) dut (
    .clk           (clk),
    .reset         (reset),
    .load          (load),
    .init_pos      (init_pos),
    .step_in       (step_in),
    .key           (key),
    .step_out      (step_out),
    .pos           (pos),
    .fwd_valid_in  (fwd_valid_in),
    .fwd_in        (fwd_in),
    .fwd_valid_out (fwd_valid_out),
    .fwd_out       (fwd_out),
    .bwd_valid_in  (bwd_valid_in),
    .bwd_in        (bwd_in),
    .bwd_valid_out (bwd_valid_out),
    .bwd_out       (bwd_out),
    .err           (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Letter substitution straight from the wiring string.
  function automatic logic [25:0] ref_map(bit bwd, int idx, int p);
    int e, w, r;
    e = (idx + p) % 26;
    w = 0;
    if (!bwd) w = int'(wiring[e]) - 65;
    else
      for (int j = 0; j < 26; j++) if (int'(wiring[j]) - 65 == e) w = j;
    r = (w - p + 26) % 26;
    return 26'd1 << r;
  endfunction

  function automatic int oh_index(logic [25:0] x);
    int idx = 0;
    for (int i = 0; i < 26; i++) if (x[i]) idx = i;
    return idx;
  endfunction

  // Apply one cycle of inputs, advance the model, then compare all outputs.
  task automatic cyc(input logic rst, input logic ld, input logic [4:0] ip,
                     input logic si, input logic k,
                     input logic fv, input logic [25:0] fi,
                     input logic bv, input logic [25:0] bi);
    bit do_step;
    reset = rst; load = ld; init_pos = ip; step_in = si; key = k;
    fwd_valid_in = fv; fwd_in = fi; bwd_valid_in = bv; bwd_in = bi;

    if (rst) begin
      m_pos = 0; m_so = 0; m_fv = 0; m_fo = '0; m_bv = 0; m_bo = '0; m_err = 0;
    end else begin
      m_fv = fv;
      if (fv) begin
        if ($countones(fi) == 1) m_fo = ref_map(0, oh_index(fi), m_pos);
        else begin m_fo = '0; m_err = 1; end
      end
      m_bv = bv;
      if (bv) begin
        if ($countones(bi) == 1) m_bo = ref_map(1, oh_index(bi), m_pos);
        else begin m_bo = '0; m_err = 1; end
      end
      do_step = si;
`ifdef ROTOR_DOUBLE_STEP_EN
      if (k && m_pos == notch) do_step = 1;
`endif
      if (ld) begin
        m_so = 0;
        if (int'(ip) <= 25) m_pos = int'(ip);
        else begin m_pos = 0; m_err = 1; end
      end else if (do_step) begin
        m_so  = (m_pos == notch);
        m_pos = (m_pos + 1) % 26;
      end else begin
        m_so = 0;
      end
    end

    @(posedge clk);
    #1;
    chk("pos",      32'(pos),           32'(m_pos));
    chk("step_out", 32'(step_out),      32'(m_so));
    chk("fwd_v",    32'(fwd_valid_out), 32'(m_fv));
    chk("fwd_out",  32'(fwd_out),       32'(m_fo));
    chk("bwd_v",    32'(bwd_valid_out), 32'(m_bv));
    chk("bwd_out",  32'(bwd_out),       32'(m_bo));
    chk("err",      32'(err),           32'(m_err));
  endtask

  task automatic idle();
    cyc(0, 0, 5'd0, 0, 0, 0, '0, 0, '0);
  endtask

  task automatic do_load(input logic [4:0] p);
    cyc(0, 1, p, 0, 0, 0, '0, 0, '0);
  endtask

  initial begin
    logic [25:0] fi, bi;
    logic        r_rst, r_ld, r_si, r_k, r_fv, r_bv;
    logic [4:0]  r_ip;

    case (ROTOR_ID)
      2: begin wiring = "AJDKSIRUXBLHWTMCQGZNPYFVOE"; notch = 4;  end
      3: begin wiring = "BDFHJLCPRTXVZNYEQGIKWUMOAS"; notch = 21; end
      default: begin wiring = "EKMFLGDQVZNTOWYHXUSPAIBRCJ"; notch = 16; end
    endcase
    m_pos = 0; m_so = 0; m_fv = 0; m_fo = '0; m_bv = 0; m_bo = '0; m_err = 0;

    // Reset state
    cyc(1, 0, 5'd0, 0, 0, 0, '0, 0, '0);
    chk("rst_pos", 32'(pos), 32'd0);

    // A -> E forward and E -> A backward at position 0
    cyc(0, 0, 5'd0, 0, 0, 1, 26'h1, 1, 26'h10);
    chk("A_to_E", 32'(fwd_out), 32'h10);
    chk("E_to_A", 32'(bwd_out), 32'h1);

    // Position B: A -> J
    do_load(5'd1);
    cyc(0, 0, 5'd0, 0, 0, 1, 26'h1, 0, '0);
    chk("B_A_to_J", 32'(fwd_out), 32'h200);

    // Step and data together use the old position
    do_load(5'd0);
    cyc(0, 0, 5'd0, 1, 0, 1, 26'h1, 0, '0);
    chk("step_old_pos", 32'(fwd_out), 32'h10);
    chk("step_pos1", 32'(pos), 32'd1);

    // Notch carry and wrap
    do_load(5'd16);
    cyc(0, 0, 5'd0, 1, 0, 0, '0, 0, '0);
    chk("notch_carry", 32'(step_out), 32'd1);
    idle();
    chk("carry_1cyc", 32'(step_out), 32'd0);
    cyc(0, 0, 5'd0, 1, 0, 0, '0, 0, '0);
    chk("no_carry17", 32'(step_out), 32'd0);
    do_load(5'd25);
    cyc(0, 0, 5'd0, 1, 0, 0, '0, 0, '0);
    chk("wrap", 32'(pos), 32'd0);

    // Key at the notch without step_in; key+step_in is a single increment
    do_load(5'(notch));
    cyc(0, 0, 5'd0, 0, 1, 0, '0, 0, '0);
    do_load(5'(notch));
    cyc(0, 0, 5'd0, 1, 1, 0, '0, 0, '0);
    chk("single_inc", 32'(pos), 32'(notch + 1));

    // Out-of-range load and non-one-hot data
    do_load(5'd30);
    chk("bad_load_err", 32'(err), 32'd1);
    cyc(0, 0, 5'd0, 0, 0, 1, 26'h3, 0, '0);
    chk("multi_hot", 32'(fwd_out), 32'd0);
    cyc(0, 0, 5'd0, 0, 0, 0, 26'h0, 1, 26'h0);

    // Load beats step; reset drops a transfer in flight
    cyc(1, 0, 5'd0, 0, 0, 0, '0, 0, '0);
    cyc(0, 1, 5'd5, 1, 0, 0, '0, 0, '0);
    chk("load_wins", 32'(pos), 32'd5);
    cyc(1, 0, 5'd0, 0, 0, 1, 26'h1, 1, 26'h1);
    chk("rst_fwd_v", 32'(fwd_valid_out), 32'd0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      r_rst = ($urandom_range(63) == 0);
      r_ld  = ($urandom_range(7) == 0);
      r_ip  = 5'($urandom_range(31));
      r_si  = 1'($urandom_range(1));
      r_k   = 1'($urandom_range(1));
      r_fv  = 1'($urandom_range(1));
      r_bv  = 1'($urandom_range(1));
      fi = ($urandom_range(15) == 0) ? 26'($urandom) : (26'd1 << $urandom_range(25));
      bi = ($urandom_range(15) == 0) ? 26'($urandom) : (26'd1 << $urandom_range(25));
      cyc(r_rst, r_ld, r_ip, r_si, r_k, r_fv, fi, r_bv, bi);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
